// File: rtl/check_strip_frame.sv
// Strip frame checker: locks onto the BCID sequence, checks payloads, keeps saturating counters.
// Optional macro STRIP_CHK_BITERR_EN adds a saturating payload bit-error counter (bit_err_cnt).
module check_strip_frame #(
    parameter int BCID_MAX   = 3563,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic         clk160,
    input  logic         reset_n,
    input  logic [103:0] frame_data,
    input  logic         frame_valid,
    input  logic [91:0]  exp_data,
    input  logic         clear_cnt,
    output logic         locked,
    output logic [1:0]   state,
    output logic [31:0]  frame_cnt,
    output logic [15:0]  bcid_err_cnt,
    output logic [15:0]  data_err_cnt,
`ifdef STRIP_CHK_BITERR_EN
    output logic [31:0]  bit_err_cnt,
`endif
    output logic         err_pulse
);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [11:0] L_BCID_MAX = 12'(BCID_MAX);
    localparam logic [3:0]  L_LOCK     = 4'(LOCK_CNT);
    localparam logic [3:0]  L_UNLOCK   = 4'(UNLOCK_CNT);
    localparam logic [9:0]  L_TIMEOUT  = 10'(TIMEOUT);

    state_t      r_state, w_state_nxt;
    logic [11:0] r_prev, w_prev_nxt;
    logic [3:0]  r_good, w_good_nxt;
    logic [3:0]  r_miss, w_miss_nxt;
    logic [9:0]  r_tmo, w_tmo_nxt;
    logic        r_locked;
    logic [31:0] r_frame_cnt;
    logic [15:0] r_bcid_err_cnt;
    logic [15:0] r_data_err_cnt;
    logic        r_err_pulse;

    logic [11:0] w_bcid;
    logic [91:0] w_payload;
    logic [12:0] w_next_bcid;
    logic        w_match;
    logic        w_bcid_err;
    logic        w_data_err;

    assign w_bcid    = frame_data[103:92];
    assign w_payload = frame_data[91:0];
    // 13-bit successor so a garbage prev_bcid of 4095 cannot alias onto BCID 0
    assign w_next_bcid = (r_prev == L_BCID_MAX) ? 13'd0 : ({1'b0, r_prev} + 13'd1);
    assign w_match     = (w_bcid <= L_BCID_MAX) && ({1'b0, w_bcid} == w_next_bcid);

    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_HUNT;
            r_prev  <= '0;
            r_good  <= '0;
            r_miss  <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= w_prev_nxt;
            r_good  <= w_good_nxt;
            r_miss  <= w_miss_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss;
        w_tmo_nxt   = r_tmo;
        w_bcid_err  = 1'b0;
        w_data_err  = 1'b0;
        if (frame_valid) begin
            w_tmo_nxt  = '0;
            w_prev_nxt = w_bcid;
            case (r_state)
                S_HUNT: begin
                    w_state_nxt = S_VERIFY;
                    w_good_nxt  = 4'd1;
                end
                S_VERIFY: begin
                    if (w_match) begin
                        w_good_nxt = r_good + 4'd1;
                        if ((r_good + 4'd1) == L_LOCK) begin
                            w_state_nxt = S_LOCKED;
                            w_miss_nxt  = '0;
                        end
                    end else begin
                        w_good_nxt = 4'd1;
                    end
                end
                S_LOCKED: begin
                    if (w_match) begin
                        w_miss_nxt = '0;
                        w_data_err = (w_payload != exp_data);
                    end else begin
                        w_bcid_err = 1'b1;
                        if ((r_miss + 4'd1) == L_UNLOCK) begin
                            w_state_nxt = S_HUNT;
                            w_good_nxt  = '0;
                            w_miss_nxt  = '0;
                        end else begin
                            w_miss_nxt = r_miss + 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_HUNT;
                    w_good_nxt  = '0;
                    w_miss_nxt  = '0;
                end
            endcase
        end else begin
            w_tmo_nxt = (r_tmo == L_TIMEOUT) ? r_tmo : (r_tmo + 10'd1);
            if (w_tmo_nxt == L_TIMEOUT) begin
                w_state_nxt = S_HUNT;
                w_good_nxt  = '0;
                w_miss_nxt  = '0;
            end
        end
    end

    // Counters clear on clear_cnt with priority over any same-cycle increment
    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt    <= '0;
            r_bcid_err_cnt <= '0;
            r_data_err_cnt <= '0;
            r_err_pulse    <= 1'b0;
            r_locked       <= 1'b0;
        end else begin
            r_err_pulse <= w_bcid_err | w_data_err;
            r_locked    <= (w_state_nxt == S_LOCKED);
            if (clear_cnt) begin
                r_frame_cnt    <= '0;
                r_bcid_err_cnt <= '0;
                r_data_err_cnt <= '0;
            end else begin
                if (frame_valid && (r_frame_cnt != '1))
                    r_frame_cnt <= r_frame_cnt + 32'd1;
                if (w_bcid_err && (r_bcid_err_cnt != '1))
                    r_bcid_err_cnt <= r_bcid_err_cnt + 16'd1;
                if (w_data_err && (r_data_err_cnt != '1))
                    r_data_err_cnt <= r_data_err_cnt + 16'd1;
            end
        end
    end

`ifdef STRIP_CHK_BITERR_EN
    logic [91:0] w_diff;
    logic [6:0]  w_popcnt;
    logic        w_bit_chk;
    logic [6:0]  r_pop;
    logic [31:0] r_bit_cnt;
    logic [32:0] w_bit_sum;

    assign w_diff    = w_payload ^ exp_data;
    assign w_bit_chk = frame_valid && (r_state == S_LOCKED) && w_match;
    assign w_bit_sum = {1'b0, r_bit_cnt} + {26'd0, r_pop};

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < 92; i++)
            w_popcnt = w_popcnt + 7'(w_diff[i]);
    end

    // One register stage between popcount and accumulate; clear also drops the pending term
    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            r_pop     <= '0;
            r_bit_cnt <= '0;
        end else if (clear_cnt) begin
            r_pop     <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_pop     <= w_bit_chk ? w_popcnt : 7'd0;
            r_bit_cnt <= w_bit_sum[32] ? 32'hFFFF_FFFF : w_bit_sum[31:0];
        end
    end

    assign bit_err_cnt = r_bit_cnt;
`endif

    assign state        = r_state;
    assign locked       = r_locked;
    assign frame_cnt    = r_frame_cnt;
    assign bcid_err_cnt = r_bcid_err_cnt;
    assign data_err_cnt = r_data_err_cnt;
    assign err_pulse    = r_err_pulse;

endmodule

// File: tb/tb_check_strip_frame.sv
// Directed bench for check_strip_frame: frame-level reference model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_check_strip_frame;

  localparam logic [91:0] EXP = 92'h5A5_A5A5_A5A5_0123_4567_89AB;

  logic         clk160 = 1'b0;
  logic         reset_n;
  logic [103:0] frame_data;
  logic         frame_valid;
  logic [91:0]  exp_data;
  logic         clear_cnt;
  logic         locked;
  logic [1:0]   state;
  logic [31:0]  frame_cnt;
  logic [15:0]  bcid_err_cnt;
  logic [15:0]  data_err_cnt;
  logic         err_pulse;
`ifdef STRIP_CHK_BITERR_EN
  logic [31:0]  bit_err_cnt;
`endif

  check_strip_frame dut (
    .clk160       (clk160),
    .reset_n      (reset_n),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .exp_data     (exp_data),
    .clear_cnt    (clear_cnt),
    .locked       (locked),
    .state        (state),
    .frame_cnt    (frame_cnt),
    .bcid_err_cnt (bcid_err_cnt),
    .data_err_cnt (data_err_cnt),
`ifdef STRIP_CHK_BITERR_EN
    .bit_err_cnt  (bit_err_cnt),
`endif
    .err_pulse    (err_pulse)
  );

  // clock / reset
  always #3 clk160 = ~clk160;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model: mode 0=HUNT 1=VERIFY 2=LOCKED
  int     m_mode, m_good, m_miss, m_prev, m_idle;
  longint m_frames, m_berr, m_derr, m_bits, m_pend;
  bit     m_pulse;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nxt(input int b);
    return (b == 3563) ? 0 : b + 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_good = 0; m_miss = 0; m_prev = 0; m_idle = 0;
    m_frames = 0; m_berr = 0; m_derr = 0; m_bits = 0; m_pend = 0;
    m_pulse = 0;
  endtask

  // advances the model by one clock edge using the inputs the DUT just sampled
  task automatic model_step();
    int b;
    logic [91:0] p;
    bit match;
    longint new_pop;
    b = int'(frame_data[103:92]);
    p = frame_data[91:0];
    m_pulse = 0;
    new_pop = 0;
    if (frame_valid) begin
      m_idle = 0;
      if (m_frames < 64'hFFFF_FFFF) m_frames++;
      match = (b <= 3563) && (b == nxt(m_prev));
      case (m_mode)
        0: begin m_mode = 1; m_good = 1; end
        1: begin
          if (match) begin
            m_good++;
            if (m_good == 4) begin m_mode = 2; m_miss = 0; end
          end else m_good = 1;
        end
        default: begin
          if (match) begin
            m_miss = 0;
            new_pop = $countones(p ^ exp_data);
            if (p !== exp_data) begin
              m_pulse = 1;
              if (m_derr < 65535) m_derr++;
            end
          end else begin
            m_pulse = 1;
            if (m_berr < 65535) m_berr++;
            m_miss++;
            if (m_miss == 4) begin m_mode = 0; m_good = 0; m_miss = 0; end
          end
        end
      endcase
      m_prev = b;
    end else begin
      if (m_idle < 1023) m_idle++;
      if (m_idle == 1023) begin m_mode = 0; m_good = 0; m_miss = 0; end
    end
    m_bits = m_bits + m_pend;
    if (m_bits > 64'hFFFF_FFFF) m_bits = 64'hFFFF_FFFF;
    m_pend = new_pop;
    if (clear_cnt) begin
      m_frames = 0; m_berr = 0; m_derr = 0; m_bits = 0; m_pend = 0;
    end
  endtask

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk160) begin
    chk("state", state, m_mode);
    chk("locked", locked, m_mode == 2);
    chk("frame_cnt", frame_cnt, m_frames);
    chk("bcid_err_cnt", bcid_err_cnt, m_berr);
    chk("data_err_cnt", data_err_cnt, m_derr);
    chk("err_pulse", err_pulse, m_pulse);
`ifdef STRIP_CHK_BITERR_EN
    chk("bit_err_cnt", bit_err_cnt, m_bits);
`endif
  end

  // driver: called at a negedge, returns at the following negedge
  task automatic cyc(input logic v, input logic [11:0] b, input logic [91:0] p, input logic clr);
    frame_valid = v;
    frame_data  = {b, p};
    clear_cnt   = clr;
    @(posedge clk160);
    model_step();
    @(negedge clk160);
  endtask

  task automatic frame(input int b, input logic [91:0] p);
    cyc(1'b1, 12'(b), p, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 12'd0, EXP, 1'b0);
  endtask

  int nb;

  initial begin
    reset_n     = 1'b1;
    frame_valid = 1'b0;
    frame_data  = '0;
    clear_cnt   = 1'b0;
    exp_data    = EXP;
    #1 reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk160);
    chk("rst_state", state, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_pulse", err_pulse, 0);
    reset_n = 1'b1;

    // acquisition: BCID 10..15, clean payload
    nb = 10;
    for (int i = 0; i < 6; i++) begin
      frame(nb, EXP);
      nb = nxt(nb);
      if (i == 2) chk("verify_after_3", state, 1);
      if (i == 3) chk("locked_after_4", locked, 1);
    end
    chk("frame_cnt_6", frame_cnt, 6);
    chk("berr_0", bcid_err_cnt, 0);
    chk("derr_0", data_err_cnt, 0);

    // payload bit 5 flipped, then 3 bits flipped
    frame(nb, EXP ^ (92'd1 << 5)); nb = nxt(nb);
    chk("derr_bit5", data_err_cnt, 1);
    chk("pulse_bit5", err_pulse, 1);
    frame(nb, EXP); nb = nxt(nb);
    chk("pulse_single", err_pulse, 0);
`ifdef STRIP_CHK_BITERR_EN
    chk("biterr_1", bit_err_cnt, 1);
`endif
    frame(nb, EXP ^ (92'd7 << 10)); nb = nxt(nb);
    chk("derr_3bits", data_err_cnt, 2);
    frame(nb, EXP); nb = nxt(nb);
`ifdef STRIP_CHK_BITERR_EN
    chk("biterr_4", bit_err_cnt, 4);
`endif

    // three bad BCIDs then a resync stays locked
    frame(100, EXP); frame(2000, EXP); frame(3000, EXP); frame(3001, EXP);
    chk("berr_3", bcid_err_cnt, 3);
    chk("resync_locked", state, 2);

    cyc(1'b0, 12'd0, EXP, 1'b1);
    chk("clear_berr", bcid_err_cnt, 0);
    chk("clear_frames", frame_cnt, 0);

    // four bad BCIDs drop lock
    frame(500, EXP); frame(900, EXP); frame(1300, EXP);
    chk("still_locked_3bad", locked, 1);
    frame(4000, EXP);
    chk("berr_4", bcid_err_cnt, 4);
    chk("unlock_state", state, 0);
    chk("unlock_locked", locked, 0);

    // relock near the top, then wrap through 3563 -> 0
    for (int b = 3559; b <= 3562; b++) frame(b, EXP);
    chk("relock_3562", state, 2);
    frame(3563, EXP); frame(0, EXP); frame(1, EXP);
    chk("wrap_berr", bcid_err_cnt, 4);
    chk("wrap_locked", locked, 1);

    // timeout after 1023 idle cycles
    repeat (1022) idle();
    chk("tmo_1022_locked", state, 2);
    idle();
    chk("tmo_hunt", state, 0);
    chk("tmo_berr_kept", bcid_err_cnt, 4);
    nb = 2;
    for (int i = 0; i < 4; i++) begin
      frame(nb, EXP);
      nb = nxt(nb);
      if (i == 2) chk("tmo_verify", state, 1);
    end
    chk("tmo_relock", locked, 1);

    // saturation of data_err_cnt
    cyc(1'b0, 12'd0, EXP, 1'b1);
    for (int i = 0; i < 70000; i++) begin
      frame(nb, EXP ^ 92'd1);
      nb = nxt(nb);
    end
    chk("derr_sat", data_err_cnt, 16'hFFFF);
    chk("frames_70000", frame_cnt, 70000);
    cyc(1'b1, 12'(nb), EXP ^ 92'd1, 1'b1); nb = nxt(nb);
    chk("clear_vs_err", data_err_cnt, 0);
    chk("clear_vs_frame", frame_cnt, 0);
    chk("clear_pulse", err_pulse, 1);

    // asynchronous reset in the middle of a frame
    frame(nb, EXP); nb = nxt(nb);
    frame_valid = 1'b1;
    frame_data  = {12'(nb), EXP};
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_state", state, 0);
    chk("arst_locked", locked, 0);
    chk("arst_frames", frame_cnt, 0);
    chk("arst_derr", data_err_cnt, 0);
    frame_valid = 1'b0;
    repeat (2) @(negedge clk160);
    reset_n = 1'b1;
    frame(50, EXP);
    chk("post_rst_hunt_frame", state, 1);
    chk("post_rst_frames", frame_cnt, 1);
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
